conv_pe_sequencer: RTL

CONV_PE_SEQUENCER -- requirements
Module: conv_pe_sequencer

---
 rtl/pe_ctrl_pkg.sv | 28 ++
 rtl/drain_counter.sv | 43 ++++
 rtl/conv_pe_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the convolution PE sequencer:
//   - pe_state_e           : sequencer FSM states
//   - DEFAULT_DRAIN_CYCLES : default number of pipeline stages flushed after
//                            the last MAC of a job
//   - drain_cnt_width()    : width of the drain down-counter for a given depth
// -----------------------------------------------------------------------------
package pe_ctrl_pkg;

    localparam int DEFAULT_DRAIN_CYCLES = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SWITCH  = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_FIN     = 3'd6
    } pe_state_e;

    // The counter is loaded with (cycles - 1), so it only needs to hold that.
    function automatic int drain_cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/drain_counter.sv
// -----------------------------------------------------------------------------
// drain_counter
// Loadable down-counter that times the pipeline flush at the end of a job.
// Ports:
//   clk, rstn    : clock, asynchronous active-low reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; saturates at zero
//   zero_o       : count is zero
// -----------------------------------------------------------------------------
module drain_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/conv_pe_sequencer.sv
// -----------------------------------------------------------------------------
// conv_pe_sequencer
// Control sequencer for one convolution processing element. A job starts with
// a one-cycle config load, then repeatedly issues MAC operand pairs for a
// window, commits the window result, advances the filter or row address
// generator, and finally flushes the datapath pipeline and pulses done.
//
// Operand handshake: av_data / av_filter act as "valid" from the operand
// sources; put_data / put_filter act as "accept". An operand pair is consumed
// in exactly the cycles where the FSM is in COMPUTE and both av_* are high;
// put_* are combinational in that cycle. Nothing is consumed in any other
// state.
//
// Ports:
//   clk, rstn                 : clock, asynchronous active-low reset
//   start                     : begin a job (ignored while busy)
//   stride_in, filter_size_in : job config, captured when start is accepted
//   av_data, av_filter        : operand availability
//   co_filter                 : current issue is the window's last MAC
//   end_of_row, end_of_filter : address-generator end flags, used in SWITCH
//   psum_full                 : Psum buffer full, only looked at in WAIT
//   ld_stride, ld_fileSize    : config register load pulse (LOAD)
//   stride, filter_size       : captured config
//   put_data, put_filter      : issue one MAC operand pair
//   clear_sum                 : clear buffers/accumulator (LOAD)
//   store_buffer              : window result committed (SWITCH)
//   next_filter, next_row     : advance address generators (SWITCH)
//   busy                      : job in progress (every state but IDLE)
//   done                      : one-cycle job-complete pulse (FIN)
//   win_count                 : windows committed in the current job
//   dbg_state_o               : current FSM state
// -----------------------------------------------------------------------------
module conv_pe_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int STRIDE_SIZE          = 3,
    parameter int FILTER_SIZE_REG_SIZE = 8,
    parameter int DRAIN_CYCLES         = DEFAULT_DRAIN_CYCLES,
    parameter int WIN_CNT_WIDTH        = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic [STRIDE_SIZE-1:0]          stride_in,
    input  logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_in,
    input  logic                            av_data,
    input  logic                            av_filter,
    input  logic                            co_filter,
    input  logic                            end_of_row,
    input  logic                            end_of_filter,
    input  logic                            psum_full,
    output logic                            ld_stride,
    output logic                            ld_fileSize,
    output logic [STRIDE_SIZE-1:0]          stride,
    output logic [FILTER_SIZE_REG_SIZE-1:0] filter_size,
    output logic                            put_data,
    output logic                            put_filter,
    output logic                            clear_sum,
    output logic                            store_buffer,
    output logic                            next_filter,
    output logic                            next_row,
    output logic                            busy,
    output logic                            done,
    output logic [WIN_CNT_WIDTH-1:0]        win_count,
    output pe_state_e                       dbg_state_o
);

    localparam int DRAIN_W = drain_cnt_width(DRAIN_CYCLES);
    // Counter runs DRAIN_CYCLES-1 .. 0, one DRAIN cycle per value.
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
        DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

    pe_state_e                       state_q, state_d;
    logic [STRIDE_SIZE-1:0]          stride_q;
    logic [FILTER_SIZE_REG_SIZE-1:0] filter_size_q;
    logic [WIN_CNT_WIDTH-1:0]        win_count_q;
    logic                            ld_q, clear_q, store_q, busy_q, done_q;

    logic issue;
    logic drain_load, drain_dec, drain_zero;

    assign issue = av_data & av_filter;

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_WAIT;
            ST_WAIT:    if (issue && !psum_full) state_d = ST_COMPUTE;
            ST_COMPUTE: begin
                if (!issue) begin
                    state_d = ST_WAIT;
                end else if (co_filter) begin
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (end_of_filter && end_of_row) begin
                    state_d = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_FIN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN:   if (drain_zero) state_d = ST_FIN;
            ST_FIN:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Load on the entry edge so the first DRAIN cycle already sees DRAIN_LOAD.
    assign drain_load = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);
    assign drain_dec  = (state_q == ST_DRAIN);

    drain_counter #(
        .W (DRAIN_W)
    ) u_drain_counter (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (drain_load),
        .load_val_i (DRAIN_LOAD),
        .dec_i      (drain_dec),
        .zero_o     (drain_zero)
    );

    // ------------------------------------------- state, config, Moore outputs
    // Moore outputs are registered from state_d so they line up with state_q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            stride_q      <= '0;
            filter_size_q <= '0;
            win_count_q   <= '0;
            ld_q          <= 1'b0;
            clear_q       <= 1'b0;
            store_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= (state_d == ST_LOAD);
            clear_q <= (state_d == ST_LOAD);
            store_q <= (state_d == ST_SWITCH);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_FIN);

            if ((state_q == ST_IDLE) && start) begin
                stride_q      <= stride_in;
                filter_size_q <= filter_size_in;
                win_count_q   <= '0;
            end else if ((state_q == ST_COMPUTE) && (state_d == ST_SWITCH)) begin
                // Count becomes visible in the SWITCH cycle, alongside store_buffer.
                win_count_q <= win_count_q + WIN_CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------- outputs
    // Issue and address-advance depend on same-cycle inputs.
    assign put_data     = (state_q == ST_COMPUTE) && issue;
    assign put_filter   = (state_q == ST_COMPUTE) && issue;
    assign next_filter  = (state_q == ST_SWITCH) && !end_of_filter;
    assign next_row     = (state_q == ST_SWITCH) && end_of_filter && !end_of_row;

    assign ld_stride    = ld_q;
    assign ld_fileSize  = ld_q;
    assign clear_sum    = clear_q;
    assign store_buffer = store_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign stride       = stride_q;
    assign filter_size  = filter_size_q;
    assign win_count    = win_count_q;
    assign dbg_state_o  = state_q;

endmodule
